// File: rtl/usb_pkg.sv
// USB receive/transmit shared definitions: controller states, PID codes, SYNC pattern.
package usb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    PID_WAIT,
    DATA_WAIT,
    WRITE,
    EOP_WAIT,
    CHK_CRC,
    DONE,
    ERR_EOP,
    ERR_IDLE
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Upper nibble of a PID byte is the one's complement of the lower nibble.
  function automatic logic pid_check(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_controller.sv
// USB packet receive FSM: validates SYNC/PID, streams payload+CRC bytes to a FIFO, checks CRC at EOP.
// Each byte is written 1 cycle after byte_received; fifo_full on an incoming byte aborts the packet.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       eop,
  input  logic       crc_ok,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_byte,
  output logic       crc_clear,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] byte_count,
  output logic       r_error,
  output logic       packet_done
);

  localparam logic [6:0] BYTE_LIMIT = 7'(MAX_BYTES + 2);

  rx_state_t state, next_state;
  logic      start;
  logic      pid_take;

  assign start    = (state == IDLE || state == ERR_IDLE) && d_edge;
  assign pid_take = (state == PID_WAIT) && !eop && byte_received && pid_check(rcv_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_byte    <= '0;
      pid        <= '0;
      pid_valid  <= 1'b0;
      byte_count <= '0;
      r_error    <= 1'b0;
    end else begin
      state <= next_state;
      if (start) begin
        r_error    <= 1'b0;
        byte_count <= '0;
        pid_valid  <= 1'b0;
      end else begin
        if (next_state == ERR_EOP || next_state == ERR_IDLE) r_error <= 1'b1;
        if (state == WRITE) byte_count <= byte_count + 7'd1;
      end
      if (pid_take) begin
        pid       <= rcv_data[3:0];
        pid_valid <= 1'b1;
      end
      if (next_state == WRITE) rx_byte <= rcv_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, ERR_IDLE: if (d_edge) next_state = SYNC_WAIT;
      SYNC_WAIT: begin
        if (eop) next_state = ERR_IDLE;
        else if (byte_received) next_state = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR_EOP;
      end
      PID_WAIT: begin
        if (eop) next_state = ERR_IDLE;
        else if (byte_received) begin
          if (!pid_check(rcv_data)) next_state = ERR_EOP;
          else begin
            case (rcv_data[3:0])
              PID_DATA0, PID_DATA1:         next_state = DATA_WAIT;
              PID_ACK, PID_NAK, PID_STALL:  next_state = EOP_WAIT;
              default:                      next_state = ERR_EOP;
            endcase
          end
        end
      end
      // EOP takes priority; a byte arriving alongside it is dropped.
      DATA_WAIT: begin
        if (eop) next_state = CHK_CRC;
        else if (byte_received) begin
          if (fifo_full || byte_count == BYTE_LIMIT) next_state = ERR_EOP;
          else next_state = WRITE;
        end
      end
      WRITE:     next_state = DATA_WAIT;
      EOP_WAIT: begin
        if (eop) next_state = DONE;
        else if (byte_received) next_state = ERR_EOP;
      end
      CHK_CRC:   next_state = (byte_count >= 7'd2 && crc_ok) ? DONE : ERR_IDLE;
      DONE:      next_state = IDLE;
      ERR_EOP:   if (eop) next_state = ERR_IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    w_enable    = (state == WRITE);
    packet_done = (state == DONE);
    crc_clear   = start && !rst;
    case (state)
      SYNC_WAIT, PID_WAIT, DATA_WAIT, WRITE, EOP_WAIT, CHK_CRC, ERR_EOP: rcving = 1'b1;
      default:                                                           rcving = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_usb_rx_controller.sv
// Directed bench for usb_rx_controller: good/handshake/error/overflow/fifo_full/CRC/reset packets.
module tb_usb_rx_controller;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       eop = 1'b0;
  logic       crc_ok = 1'b0;
  logic       fifo_full = 1'b0;
  logic       rcving, w_enable, crc_clear, pid_valid, r_error, packet_done;
  logic [7:0] rx_byte;
  logic [3:0] pid;
  logic [6:0] byte_count;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_base, done_base;
  logic [7:0] wr_log [$];

  usb_rx_controller #(.MAX_BYTES(64)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .byte_received(byte_received),
    .rcv_data(rcv_data), .eop(eop), .crc_ok(crc_ok), .fifo_full(fifo_full),
    .rcving(rcving), .w_enable(w_enable), .rx_byte(rx_byte), .crc_clear(crc_clear),
    .pid(pid), .pid_valid(pid_valid), .byte_count(byte_count), .r_error(r_error),
    .packet_done(packet_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable) begin
      wr_cnt++;
      wr_log.push_back(rx_byte);
    end
    if (packet_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    wr_base   = wr_cnt;
    done_base = done_cnt;
    wr_log.delete();
  endtask

  task automatic start_pkt(input string tag);
    d_edge = 1'b1;
    #1 chk({tag, "_crc_clear"}, 32'(crc_clear), 32'd1);
    tick(1);
    d_edge = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_received = 1'b1;
    rcv_data = b;
    tick(1);
    byte_received = 1'b0;
    tick(1);
  endtask

  task automatic pulse_eop();
    eop = 1'b1;
    tick(1);
    eop = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_rcving", 32'(rcving), 32'd0);
    chk("rst_w_enable", 32'(w_enable), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_pid", 32'(pid), 32'd0);
    chk("rst_r_error", 32'(r_error), 32'd0);
    chk("rst_crc_clear", 32'(crc_clear), 32'd0);
    rst = 1'b0;
    tick(1);

    // Good DATA0 packet: 11 22 + two CRC bytes.
    mark();
    start_pkt("p1");
    chk("p1_cnt_clr", 32'(byte_count), 32'd0);
    chk("p1_pid_valid_clr", 32'(pid_valid), 32'd0);
    chk("p1_rcving", 32'(rcving), 32'd1);
    send_byte(8'h80);
    send_byte(8'hC3);
    chk("p1_pid", 32'(pid), 32'd3);
    send_byte(8'h11);
    d_edge = 1'b1;
    #1 chk("p1_dedge_ignored", 32'(crc_clear), 32'd0);
    tick(1);
    d_edge = 1'b0;
    chk("p1_cnt_after_dedge", 32'(byte_count), 32'd1);
    send_byte(8'h22);
    send_byte(8'hAB);
    send_byte(8'hCD);
    crc_ok = 1'b1;
    pulse_eop();
    tick(2);
    crc_ok = 1'b0;
    chk("p1_writes", 32'(wr_cnt - wr_base), 32'd4);
    chk("p1_first_byte", 32'(wr_log[0]), 32'h11);
    chk("p1_last_byte", 32'(wr_log[3]), 32'hCD);
    chk("p1_byte_count", 32'(byte_count), 32'd4);
    chk("p1_pid_valid", 32'(pid_valid), 32'd1);
    chk("p1_done", 32'(done_cnt - done_base), 32'd1);
    chk("p1_r_error", 32'(r_error), 32'd0);
    chk("p1_idle_rcving", 32'(rcving), 32'd0);

    // ACK handshake.
    mark();
    start_pkt("p2");
    send_byte(8'h80);
    send_byte(8'hD2);
    pulse_eop();
    tick(1);
    chk("p2_pid", 32'(pid), 32'd2);
    chk("p2_pid_valid", 32'(pid_valid), 32'd1);
    chk("p2_writes", 32'(wr_cnt - wr_base), 32'd0);
    chk("p2_done", 32'(done_cnt - done_base), 32'd1);

    // PID check failure.
    mark();
    start_pkt("p3");
    send_byte(8'h80);
    send_byte(8'hC4);
    chk("p3_r_error_in_err", 32'(r_error), 32'd1);
    chk("p3_pid_valid", 32'(pid_valid), 32'd0);
    chk("p3_rcving_err_eop", 32'(rcving), 32'd1);
    pulse_eop();
    chk("p3_rcving_err_idle", 32'(rcving), 32'd0);
    chk("p3_r_error_held", 32'(r_error), 32'd1);
    chk("p3_writes", 32'(wr_cnt - wr_base), 32'd0);
    start_pkt("p3b");
    chk("p3_r_error_cleared", 32'(r_error), 32'd0);
    pulse_eop();
    chk("p3_eop_in_sync", 32'(r_error), 32'd1);

    // DATA1 overflow: 67 bytes with a 66-byte bound.
    mark();
    start_pkt("p4");
    send_byte(8'h80);
    send_byte(8'h4B);
    for (int i = 0; i < 67; i++) send_byte(8'(i));
    chk("p4_writes", 32'(wr_cnt - wr_base), 32'd66);
    chk("p4_byte_count", 32'(byte_count), 32'd66);
    chk("p4_r_error", 32'(r_error), 32'd1);
    chk("p4_rcving", 32'(rcving), 32'd1);
    pulse_eop();
    chk("p4_done", 32'(done_cnt - done_base), 32'd0);

    // fifo_full on the third data byte.
    mark();
    start_pkt("p5");
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h01);
    send_byte(8'h02);
    fifo_full = 1'b1;
    send_byte(8'h03);
    fifo_full = 1'b0;
    chk("p5_writes", 32'(wr_cnt - wr_base), 32'd2);
    chk("p5_r_error", 32'(r_error), 32'd1);
    pulse_eop();

    // Byte coincident with EOP is dropped; packet still completes.
    mark();
    start_pkt("p6");
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    crc_ok = 1'b1;
    eop = 1'b1;
    byte_received = 1'b1;
    rcv_data = 8'h33;
    tick(1);
    eop = 1'b0;
    byte_received = 1'b0;
    tick(2);
    crc_ok = 1'b0;
    chk("p6_writes", 32'(wr_cnt - wr_base), 32'd2);
    chk("p6_byte_count", 32'(byte_count), 32'd2);
    chk("p6_done", 32'(done_cnt - done_base), 32'd1);
    chk("p6_r_error", 32'(r_error), 32'd0);

    // Bad CRC at EOP.
    mark();
    start_pkt("p7");
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_eop();
    tick(2);
    chk("p7_r_error", 32'(r_error), 32'd1);
    chk("p7_done", 32'(done_cnt - done_base), 32'd0);
    chk("p7_rcving", 32'(rcving), 32'd0);

    // Reset mid-packet after 5 bytes.
    mark();
    start_pkt("p8");
    send_byte(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    chk("p8_count_pre", 32'(byte_count), 32'd5);
    rst = 1'b1;
    tick(1);
    chk("p8_state", 32'(dut.state), 32'(IDLE));
    chk("p8_rcving", 32'(rcving), 32'd0);
    chk("p8_byte_count", 32'(byte_count), 32'd0);
    chk("p8_pid", 32'(pid), 32'd0);
    chk("p8_pid_valid", 32'(pid_valid), 32'd0);
    chk("p8_rx_byte", 32'(rx_byte), 32'd0);
    rst = 1'b0;
    tick(3);
    chk("p8_writes", 32'(wr_cnt - wr_base), 32'd5);
    chk("p8_done", 32'(done_cnt - done_base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_controller.md
USB_RX_CONTROLLER -- requirements
Module: usb_rx_controller

Interface
REQ-001 Parameter: MAX_BYTES, default 64, maximum payload bytes per DATA packet, excluding the 2 CRC16 bytes.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 d_edge  in  1  one-cycle pulse; bus transition detected (packet start).
REQ-005 byte_received  in  1  one-cycle pulse; rcv_data valid this cycle.
REQ-006 rcv_data  in  8  decoded, destuffed byte from the shift register.
REQ-007 eop  in  1  level; SE0 end-of-packet detected.
REQ-008 crc_ok  in  1  level; CRC16 residue check passes over bytes received since crc_clear.
REQ-009 fifo_full  in  1  level; receive FIFO cannot accept a write.
REQ-010 rcving  out  1  packet reception in progress.
REQ-011 w_enable  out  1  one-cycle FIFO write strobe for the latched byte.
REQ-012 rx_byte  out  8  byte presented to FIFO with w_enable.
REQ-013 crc_clear  out  1  one-cycle pulse clearing the CRC16 checker.
REQ-014 pid  out  4  PID of current/last packet; pid_valid  out  1  pid holds a checked PID.
REQ-015 byte_count  out  7  bytes written to FIFO this packet, CRC bytes included.
REQ-016 r_error  out  1  sticky error flag; packet_done  out  1  one-cycle good-packet pulse.

Function
REQ-017 States: IDLE, SYNC_WAIT, PID_WAIT, DATA_WAIT, WRITE, EOP_WAIT, CHK_CRC, DONE, ERR_EOP, ERR_IDLE; outputs decoded from registered state (Moore) except crc_clear.
REQ-018 IDLE/ERR_IDLE + d_edge -> SYNC_WAIT; same cycle crc_clear=1; next cycle r_error=0, byte_count=0, pid_valid=0.
REQ-019 SYNC_WAIT: byte_received with rcv_data==8'h80 -> PID_WAIT; any other byte -> ERR_EOP; eop -> ERR_IDLE.
REQ-020 PID_WAIT: byte_received with rcv_data[7:4]==~rcv_data[3:0] latches pid=rcv_data[3:0], pid_valid=1; DATA0 (4'b0011)/DATA1 (4'b1011) -> DATA_WAIT; ACK/NAK/STALL (4'b0010/4'b1010/4'b1110) -> EOP_WAIT; other PIDs -> ERR_EOP.
REQ-021 PID check failure -> ERR_EOP, pid_valid stays 0; eop in PID_WAIT -> ERR_IDLE.
REQ-022 DATA_WAIT: eop -> CHK_CRC (eop wins over same-cycle byte_received; that byte dropped); byte_received with fifo_full=1 or byte_count==MAX_BYTES+2 -> ERR_EOP; otherwise latch rx_byte -> WRITE.
REQ-023 WRITE: w_enable=1 exactly one cycle, byte_count increments, -> DATA_WAIT; write latency 1 cycle after byte_received.
REQ-024 EOP_WAIT: eop -> DONE; byte_received -> ERR_EOP.
REQ-025 CHK_CRC (one cycle): byte_count>=2 and crc_ok=1 -> DONE; else set r_error -> ERR_IDLE.
REQ-026 DONE: packet_done=1 one cycle -> IDLE.
REQ-027 ERR_EOP: r_error=1, waits for eop -> ERR_IDLE; no writes. ERR_IDLE: r_error held until REQ-018.
REQ-028 rcving=1 in SYNC_WAIT, PID_WAIT, DATA_WAIT, WRITE, EOP_WAIT, CHK_CRC, ERR_EOP; 0 elsewhere.
REQ-029 byte_count saturates never: REQ-022 bound guarantees byte_count<=MAX_BYTES+2 (fits 7 bits for MAX_BYTES<=125).
REQ-030 d_edge outside IDLE/ERR_IDLE is ignored.

Reset
REQ-031 rst=1 at clock edge: state=IDLE, all outputs 0, rx_byte=0, pid=0, byte_count=0, r_error=0; reset mid-packet issues no w_enable or packet_done.

Structure
REQ-032 Package usb_pkg holds state enum, PID constants, SYNC_BYTE=8'h80; shared with usb_tx_controller.
REQ-033 Single module, no sub-module; byte counter and PID/byte latches inline.

Verification
REQ-034 Sync 80, PID C3 (DATA0), bytes 11 22 + valid CRC, eop, crc_ok=1 -> 4 w_enable pulses, byte_count=4, pid=3, packet_done once, r_error=0.
REQ-035 Sync 80, PID D2 (ACK), eop -> pid=2, pid_valid=1, no w_enable, packet_done once.
REQ-036 Sync 80, PID C4 (check fail) -> ERR_EOP, r_error=1 after eop, no writes; next d_edge clears r_error.
REQ-037 DATA1 with 67 bytes, MAX_BYTES=64 -> 66 writes then ERR_EOP, r_error=1.
REQ-038 fifo_full=1 on third data byte -> 2 writes, ERR_EOP, r_error=1; byte with eop same cycle dropped; crc_ok=0 at CHK_CRC -> r_error=1.
REQ-039 rst=1 during DATA_WAIT after 5 bytes -> all outputs 0 next cycle, state IDLE.
